cpu_ctrl_seq: RTL
=================

Name: cpu_ctrl_seq

Overview:
Multi-cycle control sequencer that drives the 19-bit ALU, which acts as the responder. It fetches 19-bit instructions over a req/valid instruction-memory handshake and decodes them. It reads operands from an internal register file, issues alu_ctrl plus operands, and then writes back the result or resolves a branch on the zero flag. It sits between instruction memory and the combinational ALU in the CPU core.

Parameters:
PC_W, 8, program counter / instruction address width; PC wraps modulo 2^PC_W
NREG, 8, register count (fixed by 3-bit register fields; do not change)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset, sampled on rising clk
imem_req  out  1  fetch request
imem_addr  out  PC_W  fetch address (= PC)
imem_valid  in  1  instruction data valid
imem_rdata  in  19  instruction word
alu_a  out  19  ALU operand A
alu_b  out  19  ALU operand B
alu_ctrl  out  3  ALU op select
alu_result  in  19  ALU result (combinational, same cycle)
alu_zero  in  1  ALU zero flag (result == 0)
halted  out  1  high while in HALT state
illegal  out  1  one-cycle pulse on an undefined opcode
dbg_sel  in  3  debug register select
dbg_data  out  19  debug read of register dbg_sel (combinational)

Behaviour:
- Instruction format: [18:15] opcode, [14:12] rd, [11:9] rs1, [8:6] rs2, [8:0] imm9, [5:0] off6. Immediates are sign-extended to 19 bits.
- Opcodes:
  - 0x0 ADD, 0x1 SUB, 0x2 AND, 0x3 OR, 0x4 XOR: rd = rs1 op rs2.
  - 0x5 ADDI: rd = rs1 + sext(imm9).
  - 0x6 BEQ: if rs1 == rs2 then PC = PC+1+sext(off6).
  - 0x7 JMP: PC = instr[PC_W-1:0].
  - 0xF HALT.
  - All others are illegal.
- alu_ctrl codes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR. ADDI uses 000. BEQ uses 001 and tests alu_zero.
- r0 always reads 0; writes to r0 are discarded.
- States: FETCH -> DECODE -> EXEC -> WB -> FETCH; HALT is terminal.
- FETCH:
  - imem_req = 1 and imem_addr = PC, held stable until imem_valid.
  - On req & valid, the instruction register captures imem_rdata and the state goes to DECODE.
  - imem_valid without req is ignored.
- DECODE:
  - Latch register-file reads of rs1/rs2 into operand registers.
  - Illegal opcode: pulse illegal for this cycle, PC = PC+1, return to FETCH, no writeback.
  - HALT: go to HALT.
  - JMP: load PC, return to FETCH.
- EXEC:
  - alu_a/alu_b/alu_ctrl are driven from registers.
  - Sample alu_result into the result register and alu_zero into a flag register at the end of the cycle.
  - BEQ: compute the new PC and go directly to FETCH (3 cycles + fetch wait).
- WB: write the result register to rd, PC = PC+1, go to FETCH. Minimum ALU-op latency is 4 cycles with zero fetch wait.
- alu_a/alu_b/alu_ctrl hold their last values outside EXEC; the ALU output is ignored there.
- Arithmetic:
  - 19-bit modulo; overflow is ignored.
  - PC arithmetic is modulo 2^PC_W. PC+1 at max wraps to 0; a negative branch offset past 0 wraps.
- HALT: halted = 1, imem_req = 0, no state change until reset.
- Reset (rst_n low at a rising edge, from any state including mid-fetch or EXEC):
  - Next state is FETCH, PC = 0, all registers 0, operand/result registers 0.
  - Outputs: imem_req = 0 during the reset cycle, imem_addr = 0, alu_a = 0, alu_b = 0, alu_ctrl = 000, halted = 0, illegal = 0.
  - An in-flight writeback is aborted.
  - imem_req rises on the first cycle after rst_n is sampled high.
- Simultaneous events: an illegal opcode and reset together give reset priority, with no pulse.

Decomposition:
- Package cpu_pkg holds:
  - opcode constants;
  - ALU_ADD..ALU_XOR alu_ctrl constants;
  - state enum (FETCH, DECODE, EXEC, WB, HALT);
  - instruction field bit positions;
  - DATA_W = 19.
- One sub-module, cpu_regfile: 8 x 19 registers, two combinational read ports plus a debug read port, one synchronous write port, r0 hardwired to zero, synchronous active-low reset clearing all registers.

Test Plan:
- Program ADDI r1,r0,25; ADDI r2,r0,10; ADD r3,r1,r2; SUB r4,r1,r2 -> in EXEC of ADD, alu_a=25, alu_b=10, alu_ctrl=000; dbg r3=35, r4=15; ADD takes 4 cycles with imem_valid tied high.
- AND/OR/XOR on r1=25, r2=10 -> alu_ctrl 010/011/100; rd = 8/27/19.
- ADDI r1,r0,15; ADDI r2,r0,15; BEQ r1,r2,+2 at PC=2 -> alu_zero=1 sampled, next imem_addr=5. With r2=14 instead -> imem_addr=3.
- imem_valid delayed 3 cycles after req -> imem_req stays high and imem_addr stays constant; instruction captured only on the valid cycle.
- Opcode 0x8 at PC=0 -> illegal high exactly 1 cycle, no register changes, next imem_addr=1. HALT -> halted=1 and imem_req=0 for 20+ cycles. Then rst_n low 1 cycle -> halted=0, imem_addr=0.
- rst_n low during EXEC of ADD r3 -> r3 stays 0; alu_ctrl=000 and PC=0 after reset; a JMP to 255 then a +1 fetch wraps imem_addr to 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants and types for the cpu_ctrl_seq sequencer and its register file.
package cpu_pkg;
  localparam int DATA_W = 19;

  // Instruction field positions
  localparam int OP_HI  = 18;
  localparam int OP_LO  = 15;
  localparam int RD_HI  = 14;
  localparam int RD_LO  = 12;
  localparam int RS1_HI = 11;
  localparam int RS1_LO = 9;
  localparam int RS2_HI = 8;
  localparam int RS2_LO = 6;
  localparam int IMM_HI = 8;
  localparam int OFF_HI = 5;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_BEQ  = 4'h6;
  localparam logic [3:0] OP_JMP  = 4'h7;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, WB, HALT} state_t;

  function automatic logic [DATA_W-1:0] sext9(input logic [8:0] v);
    return {{(DATA_W-9){v[8]}}, v};
  endfunction
endpackage

// File: rtl/cpu_regfile.sv
// 8 x 19 register file: two read ports, one debug read, one sync write; r0 reads zero.
module cpu_regfile
  import cpu_pkg::*;
#(
  parameter int NREG = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [2:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [2:0]        raddr1,
  input  logic [2:0]        raddr2,
  input  logic [2:0]        dbg_sel,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic [DATA_W-1:0] dbg_data
);
  logic [DATA_W-1:0] regs_q [NREG];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (we && waddr != 3'd0) begin
      regs_q[waddr] <= wdata;
    end
  end

  assign rdata1   = (raddr1  == 3'd0) ? '0 : regs_q[raddr1];
  assign rdata2   = (raddr2  == 3'd0) ? '0 : regs_q[raddr2];
  assign dbg_data = (dbg_sel == 3'd0) ? '0 : regs_q[dbg_sel];
endmodule

// File: rtl/cpu_ctrl_seq.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer driving an external combinational ALU.
module cpu_ctrl_seq
  import cpu_pkg::*;
#(
  parameter int PC_W = 8,
  parameter int NREG = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_valid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_ctrl,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              halted,
  output logic              illegal,
  input  logic [2:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);
  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d, opa_q, opa_d, opb_q, opb_d, res_q, res_d;
  logic [2:0]        ctrl_q, ctrl_d;
  logic              run_q, zf_q, zf_d;
  logic              we, illegal_c;
  logic [DATA_W-1:0] rd1, rd2;
  logic [3:0]        op;
  logic [PC_W-1:0]   pc_inc, br_off;

  assign op     = ir_q[OP_HI:OP_LO];
  assign pc_inc = pc_q + PC_W'(1);
  assign br_off = {{(PC_W-6){ir_q[OFF_HI]}}, ir_q[OFF_HI:0]};

  cpu_regfile #(.NREG(NREG)) u_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (we),
    .waddr   (ir_q[RD_HI:RD_LO]),
    .wdata   (res_q),
    .raddr1  (ir_q[RS1_HI:RS1_LO]),
    .raddr2  (ir_q[RS2_HI:RS2_LO]),
    .dbg_sel (dbg_sel),
    .rdata1  (rd1),
    .rdata2  (rd2),
    .dbg_data(dbg_data)
  );

  // run_q delays the first request until rst_n has been seen high once.
  assign imem_req  = (state_q == FETCH) && run_q && rst_n;
  assign imem_addr = pc_q;
  assign alu_a     = opa_q;
  assign alu_b     = opb_q;
  assign alu_ctrl  = ctrl_q;
  assign halted    = (state_q == HALT);
  assign illegal   = illegal_c && rst_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      ctrl_q  <= ALU_ADD;
      zf_q    <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      ctrl_q  <= ctrl_d;
      zf_q    <= zf_d;
      run_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    res_d     = res_q;
    ctrl_d    = ctrl_q;
    zf_d      = zf_q;
    we        = 1'b0;
    illegal_c = 1'b0;
    case (state_q)
      FETCH: if (imem_req && imem_valid) begin
        ir_d    = imem_rdata;
        state_d = DECODE;
      end
      DECODE: begin
        // Operand registers load only when heading to EXEC so the ALU inputs hold otherwise.
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
            opa_d   = rd1;
            opb_d   = rd2;
            ctrl_d  = op[2:0];
            state_d = EXEC;
          end
          OP_ADDI: begin
            opa_d   = rd1;
            opb_d   = sext9(ir_q[IMM_HI:0]);
            ctrl_d  = ALU_ADD;
            state_d = EXEC;
          end
          OP_BEQ: begin
            opa_d   = rd1;
            opb_d   = rd2;
            ctrl_d  = ALU_SUB;
            state_d = EXEC;
          end
          OP_JMP: begin
            pc_d    = ir_q[PC_W-1:0];
            state_d = FETCH;
          end
          OP_HALT: state_d = HALT;
          default: begin
            illegal_c = 1'b1;
            pc_d      = pc_inc;
            state_d   = FETCH;
          end
        endcase
      end
      EXEC: begin
        res_d = alu_result;
        zf_d  = alu_zero;
        if (op == OP_BEQ) begin
          pc_d    = alu_zero ? pc_inc + br_off : pc_inc;
          state_d = FETCH;
        end else begin
          state_d = WB;
        end
      end
      WB: begin
        we      = 1'b1;
        pc_d    = pc_inc;
        state_d = FETCH;
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end
endmodule
